// File: rtl/jelly_stream_pack_serializer.sv
// Purpose : serialize one packed N-lane word into N (or fewer) single-lane beats, in lane order.
// Latency : first beat valid one cycle after the word is accepted; back-to-back words stream at 1 beat/cycle.
// Backpressure: s_ready only while idle or while the final beat is being taken; m_* held stable while m_ready=0.
//
// Ports:
//   reset, clk, cke       synchronous active-high reset, single clock, clock enable (0 freezes everything)
//   s_data/s_num          packed word and its valid lane count (values above N saturate to N)
//   s_valid/s_ready       word handshake
//   m_data/m_index/m_last current lane, its physical lane number, final-beat flag
//   m_valid/m_ready       beat handshake

module jelly_stream_pack_serializer #(
   parameter int N           = 4,
   parameter int UNIT_WIDTH  = 8,
   parameter bit LSB_FIRST   = 1'b1,
   parameter int NUM_WIDTH   = $clog2(N + 1),
   parameter int INDEX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic                      reset,
   input  logic                      clk,
   input  logic                      cke,

   input  logic [N*UNIT_WIDTH-1:0]   s_data,
   input  logic [NUM_WIDTH-1:0]      s_num,
   input  logic                      s_valid,
   output logic                      s_ready,

   output logic [UNIT_WIDTH-1:0]     m_data,
   output logic [INDEX_WIDTH-1:0]    m_index,
   output logic                      m_last,
   output logic                      m_valid,
   input  logic                      m_ready
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [N*UNIT_WIDTH-1:0]   word_reg;
   logic [N*UNIT_WIDTH-1:0]   word_nxt;
   logic [NUM_WIDTH-1:0]      num_reg;
   logic [NUM_WIDTH-1:0]      num_nxt;
   logic [INDEX_WIDTH-1:0]    cnt;
   logic [INDEX_WIDTH-1:0]    cnt_nxt;
   logic [UNIT_WIDTH-1:0]     data_nxt;
   logic [INDEX_WIDTH-1:0]    index_nxt;
   logic                      last_nxt;
   logic [NUM_WIDTH-1:0]      num_sat;
   logic                      accept;

   // Emission position -> physical lane number.
   function automatic logic [INDEX_WIDTH-1:0] lane_of(input logic [INDEX_WIDTH-1:0] c);
      if (LSB_FIRST) begin
         return c;
      end
      return INDEX_WIDTH'(N - 1) - c;
   endfunction

   function automatic logic [UNIT_WIDTH-1:0] pick(input logic [N*UNIT_WIDTH-1:0] w,
                                                  input logic [INDEX_WIDTH-1:0]  idx);
      return w[int'(idx)*UNIT_WIDTH +: UNIT_WIDTH];
   endfunction

   // m_last is only meaningful while BUSY; in IDLE the block is ready regardless.
   assign s_ready = cke & ~reset & ((state == IDLE) | (m_ready & m_last));
   assign m_valid = (state == BUSY);
   assign accept  = s_valid & s_ready;
   assign num_sat = (int'(s_num) > N) ? NUM_WIDTH'(N) : s_num;

   always_comb begin
      state_nxt = state;
      word_nxt  = word_reg;
      num_nxt   = num_reg;
      cnt_nxt   = cnt;
      data_nxt  = m_data;
      index_nxt = m_index;
      last_nxt  = m_last;

      if ((state == BUSY) && m_ready && !m_last) begin
         // Mid-word advance; s_ready is low here so no word can be accepted.
         cnt_nxt   = cnt + 1'b1;
         index_nxt = lane_of(cnt_nxt);
         data_nxt  = pick(word_reg, index_nxt);
         last_nxt  = (int'(cnt_nxt) == int'(num_reg) - 1);
      end else if (accept && (num_sat != '0)) begin
         // Load from IDLE, or reload during the final-beat handoff with no bubble.
         state_nxt = BUSY;
         word_nxt  = s_data;
         num_nxt   = num_sat;
         cnt_nxt   = '0;
         index_nxt = lane_of('0);
         data_nxt  = pick(s_data, index_nxt);
         last_nxt  = (num_sat == NUM_WIDTH'(1));
      end else if (accept || ((state == BUSY) && m_ready)) begin
         // Empty word swallowed, or final beat taken with nothing to follow.
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         word_reg <= '0;
         num_reg  <= '0;
         cnt      <= '0;
         m_data   <= '0;
         m_index  <= '0;
         m_last   <= 1'b0;
      end else if (cke) begin
         state    <= state_nxt;
         word_reg <= word_nxt;
         num_reg  <= num_nxt;
         cnt      <= cnt_nxt;
         m_data   <= data_nxt;
         m_index  <= index_nxt;
         m_last   <= last_nxt;
      end
   end

endmodule
